// File: rtl/vga_scanout.sv
// 160x120x3 framebuffer with a plot-side write port and a 640x480@60 VGA scan-out.
// Each stored pixel is shown as a 4x4 block, and a start-of-frame pulse paces game logic.
module vga_scanout #(
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] x,
   input  logic [6:0] y,
   input  logic [2:0] colour,
   input  logic       plot,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic [9:0] VGA_R,
   output logic [9:0] VGA_G,
   output logic [9:0] VGA_B,
   output logic       frame_start
);

   localparam int FB_W     = 160;
   localparam int FB_H     = 120;
   localparam int FB_DEPTH = FB_W * FB_H;
   localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
   localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
   localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
   localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

   logic [2:0] fb_mem [0:FB_DEPTH-1];

   logic        pix_en_q, pix_en_d;
   logic        vga_clk_q;
   logic [9:0]  hcount_q, hcount_d;
   logic [9:0]  vcount_q, vcount_d;

   logic        vis_raw, hs_raw, vs_raw;
   logic [14:0] rd_addr;
   logic [14:0] wr_addr;
   logic        wr_en;

   logic [2:0]  pix_q;
   logic        vis1_q, hs1_q, vs1_q;

   logic        hs_q, vs_q, blank_n_q;
   logic [9:0]  r_q, g_q, b_q;
   logic [9:0]  r_d, g_d, b_d;

   // Pixel tick: scan logic only advances on clk edges where pix_en_q is high.
   assign pix_en_d = ~pix_en_q;

   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (pix_en_q) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            if (vcount_q == V_LAST) begin
               vcount_d = '0;
            end else begin
               vcount_d = vcount_q + 10'd1;
            end
         end else begin
            hcount_d = hcount_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pix_en_q  <= 1'b0;
         vga_clk_q <= 1'b0;
         hcount_q  <= '0;
         vcount_q  <= '0;
      end else begin
         pix_en_q  <= pix_en_d;
         vga_clk_q <= pix_en_q;
         hcount_q  <= hcount_d;
         vcount_q  <= vcount_d;
      end
   end

   assign vis_raw = (hcount_q < H_VIS_L) && (vcount_q < V_VIS_L);
   assign hs_raw  = !((hcount_q >= HS_START) && (hcount_q < HS_END));
   assign vs_raw  = !((vcount_q >= VS_START) && (vcount_q < VS_END));

   // row*160 as (row<<7)+(row<<5), column is the 4x-decimated scan position
   assign rd_addr = 15'({vcount_q[8:2], 7'd0}) + 15'({vcount_q[8:2], 5'd0})
                  + 15'(hcount_q[9:2]);

   assign wr_en   = plot && (x < 8'(FB_W)) && (y < 7'(FB_H));
   assign wr_addr = 15'({y, 7'd0}) + 15'({y, 5'd0}) + 15'(x);

   // Plot writes ignore the scan entirely; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         fb_mem[wr_addr] <= colour;
      end
   end

   // Stage 1: the read is skipped outside the visible area so rd_addr never leaves the array.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pix_q  <= '0;
         vis1_q <= 1'b0;
         hs1_q  <= 1'b1;
         vs1_q  <= 1'b1;
      end else if (pix_en_q) begin
         if (vis_raw) begin
            pix_q <= fb_mem[rd_addr];
         end
         vis1_q <= vis_raw;
         hs1_q  <= hs_raw;
         vs1_q  <= vs_raw;
      end
   end

   always_comb begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (vis1_q) begin
         r_d = {10{pix_q[2]}};
         g_d = {10{pix_q[1]}};
         b_d = {10{pix_q[0]}};
      end
   end

   // Stage 2: all DAC-side signals leave together, two ticks behind the counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
      end else if (pix_en_q) begin
         hs_q      <= hs1_q;
         vs_q      <= vs1_q;
         blank_n_q <= vis1_q;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
      end
   end

   assign VGA_CLK     = vga_clk_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_n_q;
   assign VGA_SYNC_N  = 1'b1;
   assign VGA_R       = r_q;
   assign VGA_G       = g_q;
   assign VGA_B       = b_q;
   assign frame_start = pix_en_q && (hcount_q == '0) && (vcount_q == '0);

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster; every scanned tick is compared against a
// timing/colour model fed from a shadow copy of the framebuffer.
module tb_vga_scanout;

   localparam int H_VIS   = 64;
   localparam int H_FP    = 4;
   localparam int H_SYNC  = 8;
   localparam int H_BP    = 4;
   localparam int V_VIS   = 48;
   localparam int V_FP    = 2;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 3;
   localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int F_TICKS = H_TOT * V_TOT;
   localparam int WAIT_LIMIT = 2 * F_TICKS + 20;

   logic       clk;
   logic       resetn;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
   logic [9:0] VGA_R, VGA_G, VGA_B;

   logic [32:0] exp_q[$];
   logic [2:0]  m_fb [0:119][0:159];
   int          n_assert;
   int          n_fail;

   vga_scanout #(
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
      .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
      .VGA_SYNC_N(VGA_SYNC_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .frame_start(frame_start)
   );

   // clock / reset
   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      logic [35:0] obs;
      logic [35:0] exp_v;
      obs   = {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, frame_start, VGA_SYNC_N,
               VGA_R, VGA_G, VGA_B};
      exp_v = {6'b110001, 30'd0};
      chk(tag, 40'(obs), 40'(exp_v));
   endtask

   // driver: one write per clk while called back to back
   task automatic plot_px(input int px, input int py, input logic [2:0] c);
      x      = 8'(px);
      y      = 7'(py);
      colour = c;
      plot   = 1'b1;
      if (px < 160 && py < 120) m_fb[py][px] = c;
      @(negedge clk);
   endtask

   task automatic plot_idle();
      plot = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_frame(output int waited, output bit found);
      waited = 0;
      found  = 1'b0;
      while (!found && waited < WAIT_LIMIT) begin
         @(negedge clk);
         waited++;
         if (frame_start) found = 1'b1;
      end
   endtask

   function automatic logic [32:0] model_out(input int t);
      int h, v;
      logic vis, hs, vs;
      logic [2:0] p;
      h   = t % H_TOT;
      v   = t / H_TOT;
      vis = (h < H_VIS) && (v < V_VIS);
      hs  = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
      vs  = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
      p   = vis ? m_fb[v / 4][h / 4] : 3'b000;
      return {hs, vs, vis, {10{p[2]}}, {10{p[1]}}, {10{p[0]}}};
   endfunction

   // Called at the negedge where frame_start is high (tick 0); outputs trail by 2 ticks.
   task automatic scan_frame(input string tag);
      logic [32:0] exp_v;
      logic [32:0] obs_v;
      for (int t = 0; t <= F_TICKS; t++) begin
         exp_q.push_back(model_out(t % F_TICKS));
         @(negedge clk);
         chk({tag, " vga_clk_hi"}, 40'(VGA_CLK), 40'(1));
         chk({tag, " fs_off_tick"}, 40'(frame_start), 40'(0));
         @(negedge clk);
         chk({tag, " vga_clk_lo"}, 40'(VGA_CLK), 40'(0));
         chk($sformatf("%s frame_start t=%0d", tag, t + 1), 40'(frame_start),
             40'(((t + 1) % F_TICKS) == 0));
         if (t >= 1) begin
            exp_v = exp_q.pop_front();
            obs_v = {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B};
            chk($sformatf("%s scan t=%0d", tag, t - 1), 40'(obs_v), 40'(exp_v));
         end
      end
      exp_q.delete();
   endtask

   initial begin
      int  waited;
      bit  found;
      n_assert = 0;
      n_fail   = 0;
      for (int r = 0; r < 120; r++)
         for (int c = 0; c < 160; c++) m_fb[r][c] = 3'b000;
      resetn = 1'b0;
      x = '0; y = '0; colour = '0; plot = 1'b0;

      // reset values
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_initial");

      // clear the visible area and plot one pixel
      resetn = 1'b1;
      for (int r = 0; r < V_VIS / 4; r++)
         for (int c = 0; c < H_VIS / 4; c++) plot_px(c, r, 3'b000);
      plot_px(5, 3, 3'b101);
      plot_idle();

      // reset again, then first frame_start comes on the first pix_en cycle
      #3 resetn = 1'b0;
      #1 check_reset_outputs("reset_second");
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      wait_frame(waited, found);
      chk("first_fs_after_release", 40'(waited), 40'(1));
      scan_frame("f1");

      // corner and out-of-range writes, back to back
      plot_px(15, 11, 3'b010);
      plot_px(159, 119, 3'b010);
      plot_px(160, 0, 3'b111);
      plot_px(0, 120, 3'b111);
      plot_idle();
      chk("fb_corner", 40'(dut.fb_mem[19199]), 40'(3'b010));
      chk("fb_alias_160", 40'(dut.fb_mem[160]), 40'(3'b000));
      wait_frame(waited, found);
      chk("fs_found_f2", 40'(found), 40'(1));
      scan_frame("f2");

      // mid-frame reset while the new blue pixel is on the DAC
      plot_px(10, 10, 3'b001);
      plot_idle();
      wait_frame(waited, found);
      chk("fs_found_f3", 40'(found), 40'(1));
      repeat (2 * (41 * H_TOT + 42 + 2)) @(negedge clk);
      chk("pre_reset_blank", 40'(VGA_BLANK_N), 40'(1));
      chk("pre_reset_blue", 40'({VGA_R, VGA_B}), 40'({10'h000, 10'h3FF}));
      #3 resetn = 1'b0;
      #1 check_reset_outputs("reset_mid_frame");
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_mid_frame_held");
      resetn = 1'b1;
      wait_frame(waited, found);
      chk("fs_after_mid_reset", 40'(waited), 40'(1));
      scan_frame("f3");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
